// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock and flush control for the
// 5-stage RV32I pipeline. The E-stage copies feed the execute datapath and
// the forwarding unit directly.
// Optional macro ID_EX_PERF_CNT_EN adds stall_cnt/flush_cnt event counters.
module id_ex_stage #(
   parameter int unsigned XLEN            = 32,
   parameter logic [1:0]  LOAD_RESULT_SRC = 2'b01
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      rs1D,
   input  logic [4:0]      rs2D,
   input  logic [4:0]      rdD,
   input  logic [XLEN-1:0] rd1D,
   input  logic [XLEN-1:0] rd2D,
   input  logic [XLEN-1:0] immD,
   input  logic [XLEN-1:0] pcD,
   input  logic [XLEN-1:0] pc_plus4D,
   input  logic            RegWriteD,
   input  logic            MemWriteD,
   input  logic [1:0]      ResultSrcD,
   input  logic [3:0]      ALUControlD,
   input  logic            ALUSrcD,
   input  logic            BranchD,
   input  logic            JumpD,
   input  logic            validD,
   input  logic            PCSrcE,
   input  logic            mem_stall,
   output logic [4:0]      rs1E,
   output logic [4:0]      rs2E,
   output logic [4:0]      rdE,
   output logic [XLEN-1:0] rd1E,
   output logic [XLEN-1:0] rd2E,
   output logic [XLEN-1:0] immE,
   output logic [XLEN-1:0] pcE,
   output logic [XLEN-1:0] pc_plus4E,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic [1:0]      ResultSrcE,
   output logic [3:0]      ALUControlE,
   output logic            ALUSrcE,
   output logic            BranchE,
   output logic            JumpE,
   output logic            validE,
   output logic            StallF,
   output logic            StallD,
   output logic            FlushD,
   output logic            FlushE
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt
`endif
);

   typedef struct packed {
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic            reg_write;
      logic            mem_write;
      logic [1:0]      result_src;
      logic [3:0]      alu_control;
      logic            alu_src;
      logic            branch;
      logic            jump;
      logic            valid;
   } ex_t;

   ex_t  e_q, e_d, d_in;
   logic load_use;
   logic flush_win;
   logic lu_win;

   // Bundle the decode-side fields into one record.
   always_comb begin
      d_in             = '0;
      d_in.rs1         = rs1D;
      d_in.rs2         = rs2D;
      d_in.rd          = rdD;
      d_in.rd1         = rd1D;
      d_in.rd2         = rd2D;
      d_in.imm         = immD;
      d_in.pc          = pcD;
      d_in.pc_plus4    = pc_plus4D;
      d_in.reg_write   = RegWriteD;
      d_in.mem_write   = MemWriteD;
      d_in.result_src  = ResultSrcD;
      d_in.alu_control = ALUControlD;
      d_in.alu_src     = ALUSrcD;
      d_in.branch      = BranchD;
      d_in.jump        = JumpD;
      d_in.valid       = validD;
   end

   // Load in E whose destination is read by the instruction in D.
   always_comb begin
      load_use = e_q.valid & e_q.reg_write & (e_q.result_src == LOAD_RESULT_SRC) &
                 (e_q.rd != 5'd0) & ((e_q.rd == rs1D) | (e_q.rd == rs2D)) & validD;
   end

   // Hazard outputs by priority: memory wait, taken branch, load-use.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      flush_win = 1'b0;
      lu_win    = 1'b0;
      if (mem_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
      end else if (PCSrcE) begin
         FlushD    = 1'b1;
         FlushE    = 1'b1;
         flush_win = 1'b1;
      end else if (load_use) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
         lu_win = 1'b1;
      end
   end

   // Next E contents: hold, bubble (all zero) or capture D.
   always_comb begin
      e_d = d_in;
      if (mem_stall) begin
         e_d = e_q;
      end else if (FlushE) begin
         e_d = '0;
      end
   end

   // E-stage register; reset leaves a bubble in E.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q <= '0;
      end else begin
         e_q <= e_d;
      end
   end

   assign rs1E        = e_q.rs1;
   assign rs2E        = e_q.rs2;
   assign rdE         = e_q.rd;
   assign rd1E        = e_q.rd1;
   assign rd2E        = e_q.rd2;
   assign immE        = e_q.imm;
   assign pcE         = e_q.pc;
   assign pc_plus4E   = e_q.pc_plus4;
   assign RegWriteE   = e_q.reg_write;
   assign MemWriteE   = e_q.mem_write;
   assign ResultSrcE  = e_q.result_src;
   assign ALUControlE = e_q.alu_control;
   assign ALUSrcE     = e_q.alu_src;
   assign BranchE     = e_q.branch;
   assign JumpE       = e_q.jump;
   assign validE      = e_q.valid;

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   // Count cycles where load-use or a taken branch is the winning cause.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (lu_win)    stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush_win) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_win;
   assign unused_win = lu_win ^ flush_win;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver issues one decode slot per cycle
// and queues the expected hazard outputs and next E contents from a reference
// model; a monitor pops and compares as the DUT presents them.
module tb_id_ex_stage;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        regwrite;
      logic        memwrite;
      logic [1:0]  rsrc;
      logic [3:0]  aluc;
      logic        alusrc;
      logic        branch;
      logic        jump;
      logic        valid;
   } e_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] rs1D = '0, rs2D = '0, rdD = '0;
   logic [31:0] rd1D = '0, rd2D = '0, immD = '0, pcD = '0, pc_plus4D = '0;
   logic RegWriteD = 0, MemWriteD = 0, ALUSrcD = 0, BranchD = 0, JumpD = 0, validD = 0;
   logic [1:0] ResultSrcD = '0;
   logic [3:0] ALUControlD = '0;
   logic PCSrcE = 0, mem_stall = 0;
   logic [4:0] rs1E, rs2E, rdE;
   logic [31:0] rd1E, rd2E, immE, pcE, pc_plus4E;
   logic RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, validE;
   logic [1:0] ResultSrcE;
   logic [3:0] ALUControlE;
   logic StallF, StallD, FlushD, FlushE;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .rd1D(rd1D), .rd2D(rd2D), .immD(immD),
      .pcD(pcD), .pc_plus4D(pc_plus4D), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
      .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
      .BranchD(BranchD), .JumpD(JumpD), .validD(validD), .PCSrcE(PCSrcE),
      .mem_stall(mem_stall),
      .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rd1E(rd1E), .rd2E(rd2E), .immE(immE),
      .pcE(pcE), .pc_plus4E(pc_plus4E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
      .BranchE(BranchE), .JumpE(JumpE), .validE(validE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
`ifdef ID_EX_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   e_t         exp_e_q[$];
   logic [3:0] exp_h_q[$];
   e_t         m_e;            // model of what E should hold
   int         m_stall_cnt, m_flush_cnt;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic e_t dut_e();
      e_t a;
      a.rs1 = rs1E; a.rs2 = rs2E; a.rd = rdE; a.rd1 = rd1E; a.rd2 = rd2E;
      a.imm = immE; a.pc = pcE; a.pc4 = pc_plus4E; a.regwrite = RegWriteE;
      a.memwrite = MemWriteE; a.rsrc = ResultSrcE; a.aluc = ALUControlE;
      a.alusrc = ALUSrcE; a.branch = BranchE; a.jump = JumpE; a.valid = validE;
      return a;
   endfunction

   // One decode slot: drive at negedge, predict, push expectations.
   task automatic drive(input e_t d, input logic pc, input logic ms);
      logic lu;
      logic [3:0] h;
      @(negedge clk);
      rs1D = d.rs1; rs2D = d.rs2; rdD = d.rd; rd1D = d.rd1; rd2D = d.rd2; immD = d.imm;
      pcD = d.pc; pc_plus4D = d.pc4; RegWriteD = d.regwrite; MemWriteD = d.memwrite;
      ResultSrcD = d.rsrc; ALUControlD = d.aluc; ALUSrcD = d.alusrc; BranchD = d.branch;
      JumpD = d.jump; validD = d.valid; PCSrcE = pc; mem_stall = ms;
      // A valid load in E that writes a nonzero rd read by the valid D instruction.
      lu = m_e.valid && m_e.regwrite && m_e.rsrc == 2'b01 && m_e.rd != 0 &&
           (m_e.rd == d.rs1 || m_e.rd == d.rs2) && d.valid;
      if (ms) h = 4'b1100;
      else if (pc) begin h = 4'b0011; m_flush_cnt++; end
      else if (lu) begin h = 4'b1101; m_stall_cnt++; end
      else h = 4'b0000;
      if (!ms) m_e = (pc || lu) ? e_t'(0) : d;
      exp_h_q.push_back(h);
      exp_e_q.push_back(m_e);
   endtask

   function automatic e_t rand_e();
      e_t d;
      d.rs1 = 5'($urandom_range(0, 3)); d.rs2 = 5'($urandom_range(0, 3));
      d.rd = 5'($urandom_range(0, 3));
      d.rd1 = $urandom; d.rd2 = $urandom; d.imm = $urandom; d.pc = $urandom;
      d.pc4 = $urandom; d.regwrite = 1'($urandom); d.memwrite = 1'($urandom);
      d.rsrc = 2'($urandom); d.aluc = 4'($urandom); d.alusrc = 1'($urandom);
      d.branch = 1'($urandom); d.jump = 1'($urandom);
      d.valid = ($urandom_range(0, 7) != 0);
      return d;
   endfunction

   function automatic e_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [1:0] rsrc,
                             input logic [31:0] rd1, input logic [3:0] aluc);
      e_t d = '0;
      d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.rsrc = rsrc; d.rd1 = rd1; d.aluc = aluc;
      d.regwrite = 1'b1; d.valid = 1'b1; d.pc = 32'h100; d.pc4 = 32'h104;
      return d;
   endfunction

   // Monitor: hazards just before the edge, E contents just after it.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (exp_h_q.size() > 0)
            chk("hazard{StallF,StallD,FlushD,FlushE}", 192'({StallF, StallD, FlushD, FlushE}),
                192'(exp_h_q.pop_front()));
         @(posedge clk);
         #1;
         if (exp_e_q.size() > 0) chk("E registers", 192'(dut_e()), 192'(exp_e_q.pop_front()));
      end
   end

   initial begin
      e_t ld;
      m_e = '0; m_stall_cnt = 0; m_flush_cnt = 0;
      #12;
      chk("reset validE", 192'(validE), 192'(0));
      chk("reset E all zero", 192'(dut_e()), 192'(0));
      chk("reset hazards", 192'({StallF, StallD, FlushD, FlushE}), 192'(0));
      @(negedge clk);
      rst_n = 1'b1;
      drive('0, 0, 0);
      // Pass-through
      drive(mk(5'd3, 5'd4, 5'd5, 2'b00, 32'h11, 4'h2), 0, 0);
      // Load-use: load x7 then consumer rs2=7, D held one cycle
      ld = mk(5'd1, 5'd2, 5'd7, 2'b01, 32'h0, 4'h0);
      drive(ld, 0, 0);
      drive(mk(5'd9, 5'd7, 5'd10, 2'b00, 32'h22, 4'h1), 0, 0);
      drive(mk(5'd9, 5'd7, 5'd10, 2'b00, 32'h22, 4'h1), 0, 0);
      // Load to x0 followed by rs1=0: no stall
      drive(mk(5'd1, 5'd2, 5'd0, 2'b01, 32'h0, 4'h0), 0, 0);
      drive(mk(5'd0, 5'd6, 5'd11, 2'b00, 32'h33, 4'h3), 0, 0);
      // Taken branch overrides a load-use match
      drive(ld, 0, 0);
      drive(mk(5'd7, 5'd2, 5'd12, 2'b00, 32'h44, 4'h4), 1, 0);
      // mem_stall for 3 cycles with PCSrcE, then release
      drive(mk(5'd1, 5'd2, 5'd13, 2'b00, 32'h55, 4'h5), 0, 0);
      for (int i = 0; i < 3; i++) drive(mk(5'd2, 5'd3, 5'd14, 2'b00, 32'h66, 4'h6), 1, 1);
      drive(mk(5'd2, 5'd3, 5'd14, 2'b00, 32'h66, 4'h6), 1, 0);
      // Load followed by dependent store stalls too
      drive(ld, 0, 0);
      begin
         e_t st = mk(5'd1, 5'd7, 5'd0, 2'b00, 32'h77, 4'h0);
         st.regwrite = 0; st.memwrite = 1;
         drive(st, 0, 0);
         drive(st, 0, 0);
      end
      // Randomized traffic
      for (int i = 0; i < 400; i++)
         drive(rand_e(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
      drive(mk(5'd1, 5'd2, 5'd9, 2'b00, 32'h99, 4'h9), 0, 0);
      @(posedge clk);
      #3;
      chk("scoreboard drained", 192'(exp_e_q.size() + exp_h_q.size()), 192'(0));
`ifdef ID_EX_PERF_CNT_EN
      chk("stall_cnt", 192'(stall_cnt), 192'(m_stall_cnt));
      chk("flush_cnt", 192'(flush_cnt), 192'(m_flush_cnt));
`endif
      // Asynchronous reset in mid-cycle clears E without a clock edge
      chk("E loaded before reset", 192'(rdE), 192'(9));
      rst_n = 1'b0;
      #1;
      chk("async reset validE", 192'(validE), 192'(0));
      chk("async reset E all zero", 192'(dut_e()), 192'(0));
`ifdef ID_EX_PERF_CNT_EN
      chk("async reset stall_cnt", 192'(stall_cnt), 192'(0));
      chk("async reset flush_cnt", 192'(flush_cnt), 192'(0));
`endif
      m_e = '0; m_stall_cnt = 0; m_flush_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++)
         drive(rand_e(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
      drive('0, 0, 0);
      @(posedge clk);
      #3;
      chk("scoreboard drained after reset", 192'(exp_e_q.size() + exp_h_q.size()), 192'(0));
`ifdef ID_EX_PERF_CNT_EN
      chk("stall_cnt after reset", 192'(stall_cnt), 192'(m_stall_cnt));
      chk("flush_cnt after reset", 192'(flush_cnt), 192'(m_flush_cnt));
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
